// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle of the shared memory port: fetch (i_*), load/store (d_*) and memory (mem_*) sides.
// slave is the arbiter's view; master is the view of the requesters and the memory around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D): one transaction in flight,
// D-priority with an I anti-starvation guard, flush-driven fetch drop and a response watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                err
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_D, OWN_I} owner_t;

    state_t          state;
    owner_t          owner;
    logic            drop;
    logic [SC_W-1:0] starve_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic eff_i, starved, d_wins, i_wins;
    logic in_idle, in_wait, req, gnt, timeout, resp, d_sel;

    // Handshake outputs are gated by rstn so they drop the instant reset asserts.
    always_comb begin
        eff_i   = bus.i_req & ~flush;
        starved = eff_i && (starve_cnt == SC_W'(STARVE_LIMIT));
        d_wins  = bus.d_req & ~starved;
        i_wins  = eff_i & ~d_wins;
        in_idle = rstn && (state == IDLE);
        in_wait = rstn && (state == WAIT);
        req     = in_idle & (eff_i | bus.d_req);
        gnt     = req & bus.mem_gnt;
        timeout = in_wait && !bus.mem_rvalid && (wd_cnt == WD_W'(TIMEOUT - 1));
        resp    = in_wait & (bus.mem_rvalid | timeout);
        d_sel   = req & d_wins;
    end

    always_comb begin
        bus.mem_req   = req;
        bus.mem_we    = d_sel & bus.d_we;
        bus.mem_wstrb = (d_sel & bus.d_we) ? bus.d_wstrb : 4'b0;
        bus.mem_addr  = !req ? '0 : (d_wins ? bus.d_addr : bus.i_addr);
        bus.mem_wdata = d_sel ? bus.d_wdata : 32'b0;

        bus.i_gnt     = gnt & i_wins;
        bus.d_gnt     = gnt & d_wins;
        bus.i_rvalid  = resp && (owner == OWN_I) && !drop && !flush;
        bus.d_rvalid  = resp && (owner == OWN_D);
        // A watchdog abort returns zero data rather than whatever sits on mem_rdata.
        bus.i_rdata   = (in_wait && owner == OWN_I && !timeout) ? bus.mem_rdata : 32'b0;
        bus.d_rdata   = (in_wait && owner == OWN_D && !timeout) ? bus.mem_rdata : 32'b0;
        busy          = in_wait;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            owner      <= OWN_D;
            drop       <= 1'b0;
            starve_cnt <= '0;
            wd_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt) begin
                        owner  <= d_wins ? OWN_D : OWN_I;
                        wd_cnt <= '0;
                        state  <= WAIT;
                    end
                    if (!bus.i_req || (gnt && i_wins))
                        starve_cnt <= '0;
                    else if (gnt && d_wins && eff_i && starve_cnt != SC_W'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + SC_W'(1);
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (flush && owner == OWN_I)
                        drop <= 1'b1;
                    if (resp) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                        if (timeout)
                            err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single IDLE-grant transactions followed by
// hand-written multi-cycle sequences (fetch latency, starvation, flush, watchdog, mid-flight reset).
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic busy, err;

    mem_port_arbiter_if #(.ADDR_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bus.slave), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        flush = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    typedef struct {
        string       name;
        logic        flush, i_req, d_req, d_we;
        logic [31:0] i_addr, d_addr, d_wdata;
        logic [3:0]  d_wstrb;
        logic        e_req, e_we, e_ignt, e_dgnt;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        //           name         fl  ir  dr  we  i_addr      d_addr      d_wdata     wstrb    req we ig dg e_wstrb  e_addr      e_wdata
        vecs[0] = '{"i_only",    0, 1, 0, 0, 32'h10,     32'h0,      32'h0,      4'b0000, 1, 0, 1, 0, 4'b0000, 32'h10,     32'h0};
        vecs[1] = '{"d_load",    0, 0, 1, 0, 32'h0,      32'h40,     32'h0,      4'b1111, 1, 0, 0, 1, 4'b0000, 32'h40,     32'h0};
        vecs[2] = '{"d_store",   0, 0, 1, 1, 32'h0,      32'h44,     32'h1234,   4'b0011, 1, 1, 0, 1, 4'b0011, 32'h44,     32'h1234};
        vecs[3] = '{"d_beats_i", 0, 1, 1, 0, 32'h14,     32'h48,     32'h0,      4'b0000, 1, 0, 0, 1, 4'b0000, 32'h48,     32'h0};
        vecs[4] = '{"flush_i",   1, 1, 0, 0, 32'h18,     32'h0,      32'h0,      4'b0000, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h0};
        vecs[5] = '{"flush_d_ok",1, 1, 1, 1, 32'h1C,     32'h4C,     32'h77,     4'b1000, 1, 1, 0, 1, 4'b1000, 32'h4C,     32'h77};
        vecs[6] = '{"none",      0, 0, 0, 0, 32'h0,      32'h0,      32'h0,      4'b0000, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h0};

        quiet();
        // Reset state: request held with mem_gnt, everything must stay low.
        bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.mem_gnt = 1'b1;
        #2;
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_i_gnt", bus.i_gnt, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        quiet();
        step();
        rstn = 1'b1;
        step();

        // Table: each vector is offered with mem_gnt=1; granted ones are completed in one WAIT cycle.
        for (int k = 0; k < 7; k++) begin
            flush = vecs[k].flush;
            bus.i_req = vecs[k].i_req; bus.i_addr = vecs[k].i_addr;
            bus.d_req = vecs[k].d_req; bus.d_we = vecs[k].d_we; bus.d_wstrb = vecs[k].d_wstrb;
            bus.d_addr = vecs[k].d_addr; bus.d_wdata = vecs[k].d_wdata;
            bus.mem_gnt = 1'b1;
            #1;
            chk1({vecs[k].name, "_mem_req"}, bus.mem_req, vecs[k].e_req);
            chk1({vecs[k].name, "_mem_we"}, bus.mem_we, vecs[k].e_we);
            chk({vecs[k].name, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'(vecs[k].e_wstrb));
            chk({vecs[k].name, "_mem_addr"}, bus.mem_addr, vecs[k].e_addr);
            chk({vecs[k].name, "_mem_wdata"}, bus.mem_wdata, vecs[k].e_wdata);
            chk1({vecs[k].name, "_i_gnt"}, bus.i_gnt, vecs[k].e_ignt);
            chk1({vecs[k].name, "_d_gnt"}, bus.d_gnt, vecs[k].e_dgnt);
            step();
            quiet();
            if (vecs[k].e_req) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA000_0000 + k;
                #1;
                chk1({vecs[k].name, "_busy"}, busy, 1'b1);
                chk1({vecs[k].name, "_i_rvalid"}, bus.i_rvalid, vecs[k].e_ignt);
                chk1({vecs[k].name, "_d_rvalid"}, bus.d_rvalid, vecs[k].e_dgnt);
                chk({vecs[k].name, "_i_rdata"}, bus.i_rdata, vecs[k].e_ignt ? 32'hA000_0000 + k : 32'h0);
                chk({vecs[k].name, "_d_rdata"}, bus.d_rdata, vecs[k].e_dgnt ? 32'hA000_0000 + k : 32'h0);
                step();
                quiet();
            end
        end

        // Single fetch: response on the third WAIT cycle, busy for exactly three cycles.
        bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.mem_gnt = 1'b1;
        #1;
        chk1("fetch_i_gnt", bus.i_gnt, 1'b1);
        chk1("fetch_busy_c0", busy, 1'b0);
        step();
        quiet();
        for (int c = 0; c < 2; c++) begin
            #1;
            chk1("fetch_busy_wait", busy, 1'b1);
            chk1("fetch_no_early_rvalid", bus.i_rvalid, 1'b0);
            step();
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk1("fetch_i_rvalid", bus.i_rvalid, 1'b1);
        chk("fetch_i_rdata", bus.i_rdata, 32'hDEADBEEF);
        chk1("fetch_busy_c3", busy, 1'b1);
        step();
        quiet();
        #1;
        chk1("fetch_busy_done", busy, 1'b0);
        chk1("fetch_one_pulse", bus.i_rvalid, 1'b0);

        // Contention: D wins four times, I then forced through, after which D wins again.
        for (int g = 0; g < 6; g++) begin
            bus.i_req = 1'b1; bus.i_addr = 32'h100;
            bus.d_req = 1'b1; bus.d_addr = 32'h40;
            bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0;
            #1;
            chk1("cont_d_gnt", bus.d_gnt, (g != 4));
            chk1("cont_i_gnt", bus.i_gnt, (g == 4));
            chk("cont_mem_addr", bus.mem_addr, (g == 4) ? 32'h100 : 32'h40);
            step();
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5000 + g;
            #1;
            chk1("cont_rvalid_owner", (g == 4) ? bus.i_rvalid : bus.d_rvalid, 1'b1);
            step();
        end
        quiet();
        step();

        // Flush in WAIT drops the fetch response; the next fetch is normal.
        bus.i_req = 1'b1; bus.i_addr = 32'h20; bus.mem_gnt = 1'b1;
        step();
        quiet();
        flush = 1'b1;
        #1;
        chk1("flush_wait_i_rvalid", bus.i_rvalid, 1'b0);
        step();
        flush = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111;
        #1;
        chk1("flush_dropped", bus.i_rvalid, 1'b0);
        chk1("flush_busy", busy, 1'b1);
        step();
        quiet();
        bus.i_req = 1'b1; bus.i_addr = 32'h80; bus.mem_gnt = 1'b1;
        #1;
        chk1("refetch_i_gnt", bus.i_gnt, 1'b1);
        chk("refetch_addr", bus.mem_addr, 32'h80);
        step();
        quiet();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE;
        #1;
        chk1("refetch_i_rvalid", bus.i_rvalid, 1'b1);
        chk("refetch_i_rdata", bus.i_rdata, 32'hCAFE);
        step();
        quiet();

        // Flush on the same cycle as the fetch response.
        bus.i_req = 1'b1; bus.i_addr = 32'h24; bus.mem_gnt = 1'b1;
        step();
        quiet();
        flush = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h2222;
        #1;
        chk1("flush_same_cycle", bus.i_rvalid, 1'b0);
        step();
        quiet();
        #1;
        chk1("flush_same_idle", busy, 1'b0);

        // Watchdog: D load never answered.
        bus.d_req = 1'b1; bus.d_addr = 32'h48; bus.mem_gnt = 1'b1;
        #1;
        chk1("wd_d_gnt", bus.d_gnt, 1'b1);
        step();
        quiet();
        bus.mem_rdata = 32'hFFFFFFFF;
        begin
            int early;
            early = 0;
            for (int k = 0; k < TIMEOUT - 1; k++) begin
                if (bus.d_rvalid || !busy) early++;
                step();
            end
            chk("wd_no_early_abort", 32'(early), 32'h0);
        end
        #1;
        chk1("wd_d_rvalid", bus.d_rvalid, 1'b1);
        chk("wd_d_rdata", bus.d_rdata, 32'h0);
        chk1("wd_i_rvalid", bus.i_rvalid, 1'b0);
        step();
        #1;
        chk1("wd_busy_after", busy, 1'b0);
        chk1("wd_err_set", err, 1'b1);
        bus.mem_rvalid = 1'b1;
        #1;
        chk1("wd_late_d_rvalid", bus.d_rvalid, 1'b0);
        chk1("wd_late_i_rvalid", bus.i_rvalid, 1'b0);
        step();
        quiet();
        step();
        chk1("wd_err_sticky", err, 1'b1);

        // Asynchronous reset in the middle of a fetch.
        bus.i_req = 1'b1; bus.i_addr = 32'h30; bus.mem_gnt = 1'b1;
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3333;
        #2;
        rstn = 1'b0;
        #1;
        chk1("rst_mid_i_rvalid", bus.i_rvalid, 1'b0);
        chk("rst_mid_i_rdata", bus.i_rdata, 32'h0);
        chk1("rst_mid_i_gnt", bus.i_gnt, 1'b0);
        chk1("rst_mid_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_err", err, 1'b0);
        step();
        quiet();
        rstn = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h4444;
        #1;
        chk1("post_rst_stale_rvalid", bus.i_rvalid, 1'b0);
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_err", err, 1'b0);
        step();
        quiet();
        bus.i_req = 1'b1; bus.i_addr = 32'h90; bus.mem_gnt = 1'b1;
        #1;
        chk1("post_rst_i_gnt", bus.i_gnt, 1'b1);
        step();
        quiet();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BADF00D;
        #1;
        chk1("post_rst_i_rvalid", bus.i_rvalid, 1'b1);
        chk("post_rst_i_rdata", bus.i_rdata, 32'h0BADF00D);
        step();
        quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between the instruction fetch requester (I) and the load/store requester (D).
- Sits between the fetch stage / execute-write stages and the memory.
- One outstanding transaction at a time; D has priority, with an anti-starvation guard for I.
- Flush cancels in-flight fetches on taken jumps; a watchdog recovers from a memory that never responds.

Parameters:
ADDR_W, 32, address width of all ports
STARVE_LIMIT, 4, consecutive D grants allowed while I waits before I is forced to win (>=1)
TIMEOUT, 255, max cycles in WAIT before the watchdog aborts (>=2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  pulse: drop pending/in-flight instruction fetch (jump taken)
i_req  in  1  fetch request, held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted
i_rvalid  out  1  fetch data valid (1-cycle pulse)
i_rdata  out  32  fetch data
d_req  in  1  data request, held with payload until d_gnt
d_we  in  1  1=store, 0=load
d_wstrb  in  4  byte enables for store
d_addr  in  ADDR_W  data address
d_wdata  in  32  store data
d_gnt  out  1  data request accepted
d_rvalid  out  1  load data valid / store acknowledge (1-cycle pulse)
d_rdata  out  32  load data
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_wstrb  out  4  memory byte enables (0 for reads)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory response; issued once per accepted request, including writes
mem_rdata  in  32  memory read data
busy  out  1  transaction outstanding (state != IDLE)
err  out  1  sticky: watchdog timeout occurred

Behaviour:
- Reset (async, rstn low): state=IDLE, owner=D, drop=0, starve_cnt=0, wd_cnt=0, err=0. All gnt/rvalid/mem_req outputs are forced 0 while rstn is low. Data outputs are 0.
- FSM states: IDLE, WAIT.
- IDLE:
  - eff_i = i_req & ~flush.
  - Winner: D if d_req & ~(eff_i & starve_cnt==STARVE_LIMIT); else I if eff_i.
  - mem_req = eff_i | d_req. mem_* payload is muxed combinationally from the winner. For I: mem_we=0, mem_wstrb=0.
  - winner_gnt = mem_gnt & mem_req (same cycle, combinational).
  - On grant: latch owner, wd_cnt=0, go to WAIT. D grant while I pending and lost: starve_cnt++ (saturating). I grant, or i_req low: starve_cnt=0.
  - mem_rvalid in IDLE is ignored (late response after a timeout).
- WAIT:
  - mem_req=0; gnt=0.
  - mem_rvalid: route a 1-cycle pulse to the owner's rvalid. rdata = mem_rdata, passed combinationally. If owner=I and drop=1, suppress i_rvalid. Then clear drop and go to IDLE.
  - A new grant is possible the following cycle at the earliest (one bubble between transactions).
  - flush while owner=I sets drop=1. A flush while owner=D has no effect.
  - wd_cnt increments each WAIT cycle. If wd_cnt reaches TIMEOUT-1 with no mem_rvalid: set err=1 and deliver owner rvalid with rdata=0 (still suppressed if I with drop). Clear drop and go to IDLE.
- Simultaneous events:
  - flush together with I's rvalid in WAIT: i_rvalid suppressed.
  - flush in IDLE: I cannot win that cycle, but D may.
- rdata of the non-owner port is 0.
- err is cleared only by reset.
- Mid-operation reset returns to IDLE immediately. Any memory response arriving afterwards is ignored.

Test Plan:
- Single fetch: i_req, i_addr=0x10, mem_gnt=1, mem_rvalid 3 cycles later with rdata=0xDEADBEEF -> i_gnt pulses in cycle 0; i_rvalid pulses once with 0xDEADBEEF; busy high for 3 cycles.
- Contention: i_req and d_req (load 0x40) both held continuously, mem answers after 1 cycle -> D granted 4 times in a row, then I granted; starve_cnt returns to 0 after I's grant.
- Store: d_we=1, d_wstrb=4'b0011, d_wdata=0x1234 -> mem_we=1, mem_wstrb=0011, mem_wdata=0x1234; d_rvalid acks on mem_rvalid.
- Flush: I granted at 0x20, flush pulsed in WAIT, mem_rvalid arrives -> no i_rvalid. Next I request at 0x80 is served normally.
- Timeout: D load granted, mem_rvalid never comes -> after TIMEOUT cycles d_rvalid=1 with d_rdata=0, err=1 and stays 1. A late mem_rvalid is ignored.
- Async reset asserted mid-WAIT -> outputs 0 immediately; after release, busy=0, err=0, and a fresh fetch completes normally.
